// File: rtl/adc_spi_sampler_pkg.sv
// adc_spi_sampler_pkg: shared solar-monitor ADC encodings, frame layout and command word builder
package adc_spi_sampler_pkg;
    localparam int FRAME_BITS = 16;
    localparam int RES_W = 12;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, UPDATE} state_t;
    typedef enum logic [1:0] {SEQ_IDLE, SEQ_FRAME, SEQ_GAP, SEQ_UPDATE} seq_t;
    function automatic logic [FRAME_BITS-1:0] cmd_word(input logic ch);
        return {1'b1, 1'b1, ch, 1'b1, 12'd0};
    endfunction
endpackage

// File: rtl/adc_spi_frame.sv
// adc_spi_frame: one chip-select/SCLK/shift frame to the ADC, mode 0, MSB first
module adc_spi_frame
    import adc_spi_sampler_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ch,
    input  logic             miso,
    output logic             done,
    output logic [RES_W-1:0] data,
    output logic             cs_n,
    output logic             sclk,
    output logic             mosi
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    state_t state, state_n;
    logic [7:0] cnt;
    logic [4:0] half;
    logic ch_q, tick, sample;
    logic [RES_W-1:0] sr;
    logic [FRAME_BITS-1:0] cmd;
    always_comb begin
        tick = cnt == DIV_LAST;
        sample = state == SHIFT && half[0] && cnt == 8'd0;
        cmd = cmd_word(ch_q);
        state_n = state;
        case (state)
            IDLE:     state_n = start ? CS_SETUP : IDLE;
            CS_SETUP: state_n = tick ? SHIFT : CS_SETUP;
            SHIFT:    state_n = (tick && half == 5'd31) ? CS_HOLD : SHIFT;
            CS_HOLD:  state_n = tick ? IDLE : CS_HOLD;
            default:  state_n = IDLE;
        endcase
        done = state == CS_HOLD && tick;
        cs_n = state == IDLE;
        sclk = state == SHIFT && half[0];
        // bit index advances as SCLK falls, so MOSI is stable across every rising edge
        mosi = state == CS_SETUP ? cmd[FRAME_BITS-1] :
               state == SHIFT    ? cmd[4'd15 - half[4:1]] : 1'b0;
        data = sr;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            half <= '0;
            ch_q <= 1'b0;
            sr <= '0;
        end else begin
            state <= state_n;
            cnt <= (state == IDLE || tick) ? 8'd0 : cnt + 8'd1;
            half <= state != SHIFT ? 5'd0 : tick ? half + 5'd1 : half;
            if (state == IDLE && start) ch_q <= ch;
            if (sample) sr <= {sr[RES_W-2:0], miso};
        end
    end
endmodule

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodic/software-triggered two-channel ADC conversion sequencer
module adc_spi_sampler
    import adc_spi_sampler_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             trigger,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic             adc_mosi,
    input  logic             adc_miso,
    output logic [RES_W-1:0] voltage,
    output logic [RES_W-1:0] current,
    output logic             sample_valid,
    output logic             busy,
    output logic             overrun
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [PW-1:0] PER_LAST = PW'(SAMPLE_PERIOD - 1);
    seq_t seq, seq_n;
    logic [PW-1:0] pc;
    logic [7:0] gcnt;
    logic [RES_W-1:0] v_hold, f_data;
    logic ch_q, ptick, trig, gtick, start, load, done;
    adc_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk(clk), .rst(rst), .start(start), .ch(seq != SEQ_IDLE), .miso(adc_miso),
        .done(done), .data(f_data), .cs_n(adc_cs_n), .sclk(adc_sclk), .mosi(adc_mosi)
    );
    always_comb begin
        ptick = enable && pc == PER_LAST;
        trig = trigger || ptick;
        gtick = gcnt == DIV_LAST;
        start = (seq == SEQ_IDLE && trig) || (seq == SEQ_GAP && gtick && !ch_q);
        load = seq == SEQ_GAP && gtick && ch_q;
        seq_n = seq;
        case (seq)
            SEQ_IDLE:  seq_n = trig ? SEQ_FRAME : SEQ_IDLE;
            SEQ_FRAME: seq_n = done ? SEQ_GAP : SEQ_FRAME;
            SEQ_GAP:   seq_n = !gtick ? SEQ_GAP : ch_q ? SEQ_UPDATE : SEQ_FRAME;
            default:   seq_n = SEQ_IDLE;
        endcase
        sample_valid = seq == SEQ_UPDATE;
        busy = seq != SEQ_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq <= SEQ_IDLE;
            pc <= '0;
            gcnt <= '0;
            ch_q <= 1'b0;
            v_hold <= '0;
            voltage <= '0;
            current <= '0;
            overrun <= 1'b0;
        end else begin
            seq <= seq_n;
            pc <= (!enable || ptick) ? '0 : pc + 1'b1;
            gcnt <= (seq != SEQ_GAP || gtick) ? 8'd0 : gcnt + 8'd1;
            if (start) ch_q <= seq != SEQ_IDLE;
            if (done && !ch_q) v_hold <= f_data;
            // both results land together so the UPDATE cycle shows a coherent pair
            if (load) begin
                voltage <= v_hold;
                current <= f_data;
            end
            overrun <= overrun || (trig && seq != SEQ_IDLE);
        end
    end
endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: directed/random checks of the ADC sampler against an ADC model and timing rules
module tb_adc_spi_sampler;
    localparam int D = 4;
    localparam int P = 1000;
    localparam int LAT = 70 * D + 1;
    logic clk = 0, rst = 1, enable = 0, trigger = 0, adc_miso = 0;
    logic adc_cs_n, adc_sclk, adc_mosi, sample_valid, busy, overrun;
    logic [11:0] voltage, current;
    int total = 0, bad = 0, cyc = 0;
    logic [11:0] adc_val [2];
    int nrise = 0, frames = 0, bad_gap = 0, last_rise = 0, idx;
    logic [3:0] cur_nib = 0;
    logic prev_cs = 1, prev_sclk = 0, ovr_model = 0;
    logic [3:0] nib_q [$];
    int rise_q [$];
    int sv_times [$];
    int t0, e, base, n0;
    logic got;

    adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .enable(enable), .trigger(trigger),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_mosi(adc_mosi), .adc_miso(adc_miso),
        .voltage(voltage), .current(current), .sample_valid(sample_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: 4 command bits clocked in, result shifted out MSB first after them
    always @(negedge clk) begin
        if (prev_cs && !adc_cs_n) begin
            nrise = 0;
            cur_nib = 0;
            frames++;
        end
        if (!prev_cs && adc_cs_n) begin
            nib_q.push_back(cur_nib);
            rise_q.push_back(nrise);
        end
        if (!prev_sclk && adc_sclk) begin
            if (nrise < 4) cur_nib = {cur_nib[2:0], adc_mosi};
            if (nrise > 0 && cyc - last_rise != 2 * D) bad_gap++;
            last_rise = cyc;
            nrise++;
        end
        if ((prev_sclk && !adc_sclk) || (prev_cs && !adc_cs_n)) begin
            idx = 15 - nrise;
            adc_miso = (nrise >= 4 && nrise < 16) ? adc_val[cur_nib[1]][idx] : 1'b0;
        end
        if (sample_valid) sv_times.push_back(cyc);
        prev_cs = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_pair(input logic [11:0] v, input logic [11:0] c, input int re, input string tag);
        adc_val[0] = v;
        adc_val[1] = c;
        nib_q.delete();
        rise_q.delete();
        bad_gap = 0;
        if (re != 0) ovr_model = 1;
        @(negedge clk);
        trigger = 1;
        t0 = cyc;
        @(negedge clk);
        trigger = 0;
        chk({tag, "_busy"}, busy, 1);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            trigger = (re != 0 && cyc - t0 == re);
            if (sample_valid) got = 1;
        end
        trigger = 0;
        chk({tag, "_done"}, got, 1);
        chk({tag, "_lat"}, cyc - t0, LAT);
        chk({tag, "_volt"}, voltage, v);
        chk({tag, "_curr"}, current, c);
        chk({tag, "_ovr"}, overrun, ovr_model);
        chk({tag, "_frames"}, nib_q.size(), 2);
        chk({tag, "_cmd0"}, nib_q[0], 4'b1101);
        chk({tag, "_cmd1"}, nib_q[1], 4'b1111);
        chk({tag, "_rise0"}, rise_q[0], 16);
        chk({tag, "_rise1"}, rise_q[1], 16);
        chk({tag, "_sclk_half"}, bad_gap, 0);
        @(negedge clk);
        chk({tag, "_sv_pulse"}, sample_valid, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        adc_val[0] = 0;
        adc_val[1] = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 0);
        chk("rst_mosi", adc_mosi, 0);
        chk("rst_volt", voltage, 0);
        chk("rst_curr", current, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        rst = 0;
        repeat (3) @(negedge clk);

        run_pair(12'hABC, 12'h123, 0, "basic");
        run_pair(12'hFFF, 12'h000, 0, "edge_a");
        run_pair(12'h000, 12'hFFF, 0, "edge_b");
        for (int k = 0; k < 4; k++) run_pair(12'($urandom), 12'($urandom), 0, "rand");

        run_pair(12'hABC, 12'h123, 100, "ovr");
        repeat (50) @(negedge clk);
        chk("ovr_sticky", overrun, 1);

        adc_val[0] = 12'h5A5;
        adc_val[1] = 12'hA5A;
        base = frames;
        @(negedge clk);
        trigger = 1;
        @(negedge clk);
        trigger = 0;
        for (int i = 0; i < 400 && !(frames == base + 2 && nrise >= 6); i++) @(negedge clk);
        chk("mid_reached", frames == base + 2 && nrise >= 6, 1);
        n0 = sv_times.size();
        rst = 1;
        ovr_model = 0;
        #1;
        chk("mid_cs_n", adc_cs_n, 1);
        chk("mid_sclk", adc_sclk, 0);
        chk("mid_busy", busy, 0);
        chk("mid_volt", voltage, 0);
        chk("mid_curr", current, 0);
        chk("mid_ovr", overrun, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (400) @(negedge clk);
        chk("mid_no_sv", sv_times.size(), n0);
        chk("mid_volt_hold", voltage, 0);
        run_pair(12'h321, 12'hCDE, 0, "post_rst");

        // periodic triggers, with a coincident port trigger on the first wrap
        base = sv_times.size();
        @(negedge clk);
        enable = 1;
        e = cyc;
        for (int i = 0; i < 5300; i++) begin
            @(negedge clk);
            trigger = (cyc == e + P - 1);
        end
        trigger = 0;
        enable = 0;
        repeat (300) @(negedge clk);
        chk("per_count", sv_times.size() - base, 5);
        for (int k = 0; k < 5; k++) chk("per_time", sv_times[base + k], e + P - 1 + LAT + k * P);
        chk("per_ovr", overrun, 0);

        // enable dropped mid-pair: the pair still completes
        @(negedge clk);
        enable = 1;
        e = cyc;
        for (int i = 0; i < 1100 && !busy; i++) @(negedge clk);
        chk("en_drop_start", busy, 1);
        enable = 0;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (sample_valid) got = 1;
        end
        chk("en_drop_done", got, 1);
        chk("en_drop_time", cyc, e + P - 1 + LAT);
        chk("en_drop_volt", voltage, adc_val[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 1000: clk cycles between periodic triggers; SHALL be > 70*CLK_DIV+4.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  permits periodic triggers.
REQ-006 SHALL have port trigger  input  1  single-cycle software start, honoured regardless of enable.
REQ-007 SHALL have port adc_cs_n  output  1  ADC chip select, active-low.
REQ-008 SHALL have port adc_sclk  output  1  SPI clock, mode 0, idle low.
REQ-009 SHALL have port adc_mosi  output  1  command bits to ADC.
REQ-010 SHALL have port adc_miso  input  1  data from ADC.
REQ-011 SHALL have port voltage  output  12  latest channel-0 result, feeds monitor voltage input.
REQ-012 SHALL have port current  output  12  latest channel-1 result, feeds monitor current input.
REQ-013 SHALL have port sample_valid  output  1  one-cycle pulse when voltage/current update.
REQ-014 SHALL have port busy  output  1  high while a conversion pair is in progress.
REQ-015 SHALL have port overrun  output  1  sticky: trigger arrived while busy.

Function
REQ-016 Period counter SHALL count 0..SAMPLE_PERIOD-1 while enable=1, raising an internal trigger on wrap; enable=0 holds counter at 0.
REQ-017 Any trigger (periodic or trigger port) in IDLE SHALL start a pair: channel 0 frame, then channel 1 frame.
REQ-018 FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP, UPDATE; IDLE->CS_SETUP on trigger; CS_SETUP->SHIFT after CLK_DIV cycles; SHIFT->CS_HOLD after 16 SCLK periods; CS_HOLD->GAP after CLK_DIV cycles; GAP->CS_SETUP (channel 1) or ->UPDATE (after channel 1) after CLK_DIV cycles; UPDATE->IDLE after 1 cycle.
REQ-019 adc_cs_n SHALL be low in CS_SETUP, SHIFT, CS_HOLD; high otherwise.
REQ-020 In SHIFT, adc_sclk SHALL toggle every CLK_DIV cycles, starting low, 16 rising edges per frame; low in all other states.
REQ-021 adc_mosi SHALL present frame bits MSB first, changed on SCLK falling edges (bit 15 valid from CS_SETUP entry): bits 15..12 = {1, 1, ch, 1}, bits 11..0 = 0.
REQ-022 adc_miso SHALL be sampled in the clk cycle adc_sclk rises; result = last 12 sampled bits, MSB first.
REQ-023 voltage and current SHALL update together only in UPDATE, with sample_valid=1 for exactly that cycle.
REQ-024 sample_valid SHALL assert 70*CLK_DIV+1 cycles after the trigger cycle (281 at CLK_DIV=4).
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Trigger (either source) while busy SHALL be dropped and SHALL set overrun; a periodic and a port trigger in the same IDLE cycle SHALL start one pair and not set overrun.
REQ-027 Deasserting enable mid-pair SHALL not abort it; the pair completes normally.

Reset
REQ-028 On rst: FSM=IDLE, adc_cs_n=1, adc_sclk=0, adc_mosi=0, voltage=0, current=0, sample_valid=0, busy=0, overrun=0, period counter=0.
REQ-029 rst asserted mid-frame SHALL immediately raise adc_cs_n and discard partial data; outputs keep no partial result.

Structure
REQ-030 FSM state encodings, frame length (16), command nibble layout and result width (12) SHALL live in the shared solar-monitor package/include.
REQ-031 One sub-module adc_spi_frame SHALL own one CS/SCLK/shift frame (start, ch in; done, data[11:0] out); adc_spi_sampler owns period timer, channel sequencing, output registers, overrun.

Verification
REQ-032 ADC model returns 0xABC on ch0, 0x123 on ch1, trigger pulse -> voltage=0xABC, current=0x123, single sample_valid at cycle 281 (CLK_DIV=4).
REQ-033 Capture MOSI on SCLK rising edges -> first 4 bits 1101 in frame 0, 1111 in frame 1; 16 SCLK rising edges per frame; SCLK half-period 4 clk.
REQ-034 enable=1, SAMPLE_PERIOD=1000 for 5000 cycles -> exactly 5 sample_valid pulses spaced 1000 cycles; overrun=0.
REQ-035 trigger pulse at cycle 100 after a start -> conversion unaffected, overrun=1 and stays 1 until rst.
REQ-036 rst asserted during channel-1 SHIFT -> adc_cs_n=1 same cycle, voltage=current=0, no sample_valid; next trigger completes correctly.
REQ-037 ADC returns 0xFFF and 0x000 -> voltage=0xFFF, current=0x000 (boundary values, no bit slip).
